// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//
// Iterative multiply/divide unit for the EX stage. Computes MULT/MULTU/DIV/DIVU
// results into the architectural HI/LO registers one bit per cycle and serves
// single-cycle MTHI/MTLO writes. A start/busy/done handshake lets the hazard
// logic stall the pipeline while an operation is running.
//
// Configuration macro:
//   ALU_MULDIV_DIV_EN  - when defined, the restoring divider is built and
//                        DIV/DIVU are executed. When undefined, DIV/DIVU starts
//                        are ignored and only the multiply path exists.
//
// Parameters:
//   WIDTH  operand and HI/LO width (>= 4, even)
//   CNT_W  iteration counter width (derived, do not override)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears all state
//   start  in   operation request, sampled only while busy=0
//   op     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A      in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B      in   rt operand (multiplier / divisor)
//   flush  in   abort the in-flight operation
//   busy   out  high while a MULT/DIV operation is in progress
//   done   out  one-cycle pulse when HI/LO take a MULT/DIV result
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef ALU_MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    // Multiply: {partial product high, multiplier/low product}.
    // Divide:   {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw_r;     // unmodified dividend for divide-by-zero
    logic                 is_div_r;
    logic                 neg_res_r;   // negate product / quotient in FIX
    logic                 neg_rem_r;   // negate remainder in FIX
    logic                 dbz_r;       // divisor was zero

    logic                 is_signed_s;
    logic                 mul_req_s;
    logic                 div_req_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    // Request decode and operand magnitudes for the start cycle
    always_comb begin
        is_signed_s = (op == OP_MULT) || (op == OP_DIV);
        mul_req_s   = (op == OP_MULT) || (op == OP_MULTU);
        if ((op == OP_DIV) || (op == OP_DIVU)) begin
            div_req_s = DIV_EN;
        end else begin
            div_req_s = 1'b0;
        end
        accept_s = mul_req_s || div_req_s;
        if (is_signed_s && A[WIDTH-1]) begin
            mag_a_s = -A;
        end else begin
            mag_a_s = A;
        end
        if (is_signed_s && B[WIDTH-1]) begin
            mag_b_s = -B;
        end else begin
            mag_b_s = B;
        end
    end

    // Shift-add multiply step: add multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right by one
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH-1:0]     div_sub_s;

    // Restoring divide step: shift in the next dividend bit and subtract the
    // divisor when the partial remainder is large enough
    always_comb begin
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_sub_s   = WIDTH'(div_shift_s - {1'b0, opnd_r});
        if (div_shift_s >= {1'b0, opnd_r}) begin
            div_next_s = {div_sub_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end
`else
    // Divider absent: the divide step is never selected
    always_comb begin
        div_next_s = acc_r;
    end
`endif

    // Sign correction and result selection applied in FIX
    always_comb begin
        prod_s = neg_res_r ? -acc_r : acc_r;
        quo_s  = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            if (dbz_r) begin
                fix_hi_s = a_raw_r;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_hi_s = rem_s;
                fix_lo_s = quo_s;
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            a_raw_r   <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dbz_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // flush drops a start presented in the same cycle
                    if (!flush && start) begin
                        case (op)
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: begin
                                if (accept_s) begin
                                    state_r   <= ST_CALC;
                                    busy      <= 1'b1;
                                    cnt_r     <= CNT_W'(WIDTH - 1);
                                    is_div_r  <= div_req_s;
                                    a_raw_r   <= A;
                                    neg_res_r <= is_signed_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                                    neg_rem_r <= is_signed_s && A[WIDTH-1];
                                    dbz_r     <= div_req_s && (B == {WIDTH{1'b0}});
                                    if (div_req_s) begin
                                        acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
                                        opnd_r <= mag_b_s;
                                    end else begin
                                        acc_r  <= {{WIDTH{1'b0}}, mag_b_s};
                                        opnd_r <= mag_a_s;
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        acc_r <= is_div_r ? div_next_s : mul_next_s;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    if (!flush) begin
                        hi   <= fix_hi_s;
                        lo   <= fix_lo_s;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

    localparam int W = 32;

`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    // architectural HI/LO as the reference model sees them
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference: plain 64-bit arithmetic on the architectural semantics
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output bit active, output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb, ps, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = m_hi;
        rl = m_lo;
        active = 1'b0;
        case (o)
            3'd0: begin
                active = 1'b1;
                ps = sa * sb;
                rh = ps[63:32];
                rl = ps[31:0];
            end
            3'd1: begin
                active = 1'b1;
                pu = ua * ub;
                rh = pu[63:32];
                rl = pu[31:0];
            end
            3'd2: begin
                if (DIV_EN) begin
                    active = 1'b1;
                    if (b == 32'd0) begin
                        rh = a;
                        rl = 32'hFFFF_FFFF;
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                        rh = r[31:0];
                        rl = q[31:0];
                    end
                end
            end
            3'd3: begin
                if (DIV_EN) begin
                    active = 1'b1;
                    if (b == 32'd0) begin
                        rh = a;
                        rl = 32'hFFFF_FFFF;
                    end else begin
                        qu = ua / ub;
                        ru = ua % ub;
                        rh = ru[31:0];
                        rl = qu[31:0];
                    end
                end
            end
            default: active = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present a request for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    // Called at the negedge after the accepting edge; checks latency and result
    task automatic expect_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input string name, input bit chain,
                                 input logic [2:0] no, input logic [31:0] na, input logic [31:0] nb);
        bit          act;
        logic [31:0] eh, el;
        int          bad;
        model(o, a, b, act, eh, el);
        bad = 0;
        if (act) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_after_start got %b want 1", name, busy);
            end
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s calc_window bad_cycles %0d want 0", name, bad);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_latency got done=%b busy=%b want done=1 busy=0", name, done, busy);
            end
            checks++;
            if (hi !== eh || lo !== el) begin
                errors++;
                $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, eh, el);
            end
            m_hi = eh;
            m_lo = el;
            if (chain) begin
                start = 1'b1;
                op = no;
                A = na;
                B = nb;
            end
            @(negedge clk);
            if (chain) begin
                start = 1'b0;
                A = $urandom;
                B = $urandom;
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse_width got %b want 0", name, done);
            end
        end else begin
            for (int k = 0; k <= W + 1; k++) begin
                if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s ignored_op bad_cycles %0d want 0", name, bad);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 3'd0;
        A = 32'd0;
        B = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        // preload HI/LO so the mid-operation reset has something to clear
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        issue(3'b101, 32'h0BAD_F00D, 32'd0);
        checks++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL reset_preload got hi=%h lo=%h want deadbeef 0badf00d", hi, lo);
        end
        issue(3'b000, 32'h1234_5678, 32'h0000_0077);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_calc got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (W + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_stays_idle got busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1;
        op = 3'b100;
        A = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi got hi=%h lo=%h busy=%b done=%b want hi=12345678 lo=%h 0 0", hi, lo, busy, done, m_lo);
        end
        op = 3'b101;
        A = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want 12345678 9abcdef0 0 0", hi, lo, busy, done);
        end
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;
    endtask

    task automatic test_vectors();
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        expect_result(3'b000, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b001, 32'hFFFF_FFFD, 32'd5);
        expect_result(3'b001, 32'hFFFF_FFFD, 32'd5, "multu_x5", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        expect_result(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_result(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b011, 32'd7, 32'd0);
        expect_result(3'b011, 32'd7, 32'd0, "divu_by_zero", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b010, 32'hFFFF_FFF0, 32'd0);
        expect_result(3'b010, 32'hFFFF_FFF0, 32'd0, "div_by_zero", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b110, 32'd3, 32'd4);
        expect_result(3'b110, 32'd3, 32'd4, "op110_ignored", 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'b111, 32'd3, 32'd4);
        expect_result(3'b111, 32'd3, 32'd4, "op111_ignored", 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic test_flush();
        int bad;
        issue(3'b001, 32'd2, 32'd3);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op = 3'b000;
        A = $urandom;
        B = $urandom;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc got busy=%b done=%b want 0 0", busy, done);
        end
        bad = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_quiet bad_cycles %0d want 0", bad);
        end
        issue(3'b001, 32'd2, 32'd3);
        expect_result(3'b001, 32'd2, 32'd3, "multu_after_flush", 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL multu_2x3 got hi=%h lo=%h want 0 6", hi, lo);
        end
        // flush landing on the FIX edge
        issue(3'b000, 32'h0001_0003, 32'hFFFF_0101);
        repeat (W) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL flush_fix got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo);
        end
        // flush in IDLE drops a simultaneous start
        start = 1'b1;
        flush = 1'b1;
        op = 3'b000;
        A = 32'd9;
        B = 32'd9;
        @(negedge clk);
        op = 3'b100;
        A = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL flush_idle_start got busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        issue(3'b000, a1, b1);
        expect_result(3'b000, a1, b1, "b2b_first", 1'b1, 3'b001, a2, b2);
        expect_result(3'b001, a2, b2, "b2b_second", 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            issue(o, a, b);
            expect_result(o, a, b, "random", 1'b0, 3'd0, 32'd0, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_vectors();
        test_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit for the EX stage, alongside the single-cycle ALU. It computes MIPS MULT/MULTU/DIV/DIVU results into architectural HI/LO registers and serves MTHI/MTLO writes. It uses a start/busy/done handshake so hazard logic can stall the pipeline while an operation runs. All arithmetic is iterative, one bit per cycle, and takes no multiplier macros.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high; clears all state.
- start  in  1: request; sampled only when busy=0.
- op  in  3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- A  in  WIDTH: rs operand (multiplicand/dividend; MTHI/MTLO source).
- B  in  WIDTH: rt operand (multiplier/divisor).
- flush  in  1: abort the in-flight operation.
- busy  out  1: high while an operation is in progress.
- done  out  1: one-cycle pulse when HI/LO take a MULT/DIV result.
- hi  out  WIDTH: HI register.
- lo  out  WIDTH: LO register.

## Operation
- The FSM has three states:
  - IDLE: waits for a request.
  - CALC: iterates for exactly WIDTH cycles; the counter counts down from WIDTH-1 to 0.
  - FIX: one cycle; applies sign correction and writes HI/LO.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers 0.
- IDLE & start & op=MTHI → hi<=A. IDLE & start & op=MTLO → lo<=A. Both stay in IDLE; busy and done stay low.
- IDLE & start & op∈{MULT..DIVU}:
  - Latch the operand magnitudes and the result-sign flags, then go to CALC.
  - Signed ops take the absolute value of each negative operand. Unsigned ops use the raw operands.
- Multiply is shift-add on the magnitudes and produces a 2·WIDTH product. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - The signed product is negated in FIX when sign(A) ≠ sign(B).
- Divide is restoring, one quotient bit per CALC cycle.
  - LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - Signed −2^(WIDTH−1) / −1 gives LO = 100…0 and HI = 0, with no trap.
- Divide by zero (B=0, signed or unsigned) still takes the full latency. Result: LO = all ones, HI = A unmodified.
- FIX: writes HI/LO, pulses done, returns to IDLE.
- Any start arriving while busy=1 is ignored and not queued. HI/LO keep the old values until FIX.
- flush in CALC or FIX: return to IDLE on that edge. HI/LO are unchanged, done is not pulsed, and busy falls next cycle.
  - flush in IDLE with start: the start is dropped.
- reset has priority over flush, and flush over start.

## Timing
- Start accepted at edge E0; busy=1 from after E0.
- Edges E1..E_WIDTH are CALC. E_(WIDTH+1) is FIX: hi/lo update, done=1, busy=0 after that edge.
- The MULT/DIV result is therefore visible WIDTH+1 cycles after the accepting edge, i.e. 33 cycles at WIDTH=32.
- A new start may be accepted in the same cycle done is high, because busy is already 0.
- MTHI/MTLO take effect on the accepting edge, giving a 1-cycle write.
- Outputs are registered; there are no combinational paths from inputs to busy/done/hi/lo.
- Operands A and B need only be valid in the start cycle.

## Configuration
- ALU_MULDIV_DIV_EN defined: full unit as above.
- Not defined: the divide datapath is removed.
  - DIV/DIVU starts are ignored: busy stays 0, no done pulse, HI/LO unchanged.
  - MULT, MULTU, MTHI and MTLO behave identically to the full unit.

## Test plan
- Reset mid-CALC (cycle 10 of MULT) → next cycle busy=0, done=0, hi=0, lo=0.
- MULT A=0xFFFFFFFD (−3), B=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once. MULTU with the same operands → hi=0x4, lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU A=7, B=0 → lo=0xFFFFFFFF, hi=0x7 after 33 cycles. Without ALU_MULDIV_DIV_EN → busy never rises and hi/lo stay unchanged.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on the next cycle → hi/lo update 1 cycle after each start; busy and done stay 0.
- MULTU 2×3 with flush at CALC cycle 5 and a second start during busy → no done, hi/lo unchanged. A subsequent MULTU 2×3 → lo=6, hi=0.
